// File: rtl/regfile_ctl.sv
// regfile_ctl: parametrised general-purpose register file for the single-cycle
// CPU datapath.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   we, waddr, wdata    write port; freeze holds off every write while high
//   raddr1/2, rdata1/2  combinational read ports (optional write bypass)
//   busy                high while the reset initialisation sequence runs
//   wr_valid            one-cycle pulse after each committed write
//   last_waddr/wdata    address and data of the most recent committed write
//   dbg_scan_en         1 = debug port follows the auto-scan counter
//   dbg_addr            manual debug address (used when dbg_scan_en = 0)
//   dbg_idx, dbg_data   register shown on the debug port and its contents
//
// Write-report protocol: wr_valid is a pure valid strobe with no ready
// (the consumer cannot stall it). When wr_valid is high, last_waddr and
// last_wdata describe the write that committed on the previous rising edge;
// back-to-back commits keep wr_valid high with fresh data each cycle.
// last_* hold their value while wr_valid is low.
//
// The FSM state is observable through busy (busy = state is INIT).

module regfile_ctl #(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 32,
  parameter int ADDR_W    = 5,
  parameter int INIT_MODE = 1,
  parameter int BYPASS    = 1,
  parameter int SCAN_DIV  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] last_waddr,
  output logic [DATA_W-1:0] last_wdata,
  input  logic              dbg_scan_en,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [ADDR_W-1:0] dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] init_val;
  logic              commit;

  logic [ADDR_W-1:0] scan_idx;
  logic [DIV_W-1:0]  div_cnt;

  // Register 0 is hard-wired to zero, so writes to it never commit.
  assign commit = (state == ST_RUN) && we && !freeze && (waddr != '0);

  assign busy = (state == ST_INIT);

  always_comb begin
    init_val = '0;
    if (INIT_MODE != 0) init_val = DATA_W'(init_cnt);
  end

  // Sequencer, register array and write report. The array itself is not
  // reset: the INIT sequence walks every entry once after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      wr_valid   <= 1'b0;
      last_waddr <= '0;
      last_wdata <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          wr_valid     <= 1'b0;
          rf[init_cnt] <= init_val;
          init_cnt     <= init_cnt + 1'b1;
          if (init_cnt == LAST_IDX) state <= ST_RUN;
        end
        ST_RUN: begin
          if (commit) begin
            rf[waddr]  <= wdata;
            wr_valid   <= 1'b1;
            last_waddr <= waddr;
            last_wdata <= wdata;
          end else begin
            wr_valid <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Read port 1: zero register, then busy blanking, then bypass, then array.
  always_comb begin
    rdata1 = '0;
    if (raddr1 == '0 || busy) rdata1 = '0;
    else if ((BYPASS != 0) && commit && (waddr == raddr1)) rdata1 = wdata;
    else rdata1 = rf[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 == '0 || busy) rdata2 = '0;
    else if ((BYPASS != 0) && commit && (waddr == raddr2)) rdata2 = wdata;
    else rdata2 = rf[raddr2];
  end

  // Auto-scan for the board display. Scanning keeps running during INIT so
  // the display shows initialisation progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx <= '0;
      div_cnt  <= '0;
    end else if (dbg_scan_en) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        scan_idx <= scan_idx + 1'b1;  // NREGS is a power of two: wraps naturally
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      div_cnt <= '0;
    end
  end

  assign dbg_idx = dbg_scan_en ? scan_idx : dbg_addr;

  // No bypass and no busy blanking: the display shows raw array contents.
  always_comb begin
    dbg_data = '0;
    if (dbg_idx != '0) dbg_data = rf[dbg_idx];
  end

endmodule
